// File: rtl/mux_2x1_rr_merge_if.sv
// Two-source merge bundle: A and B valid/ready input streams, one registered output stream and the grant.
interface mux_2x1_rr_merge_if #(
  parameter int WIDTH = 8
);
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_last;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_sel;
  logic             sel;

  modport master (
    output a_valid, a_data, a_last,
    output b_valid, b_data, b_last,
    output out_ready,
    input  a_ready, b_ready,
    input  out_valid, out_data, out_last, out_sel, sel
  );

  modport slave (
    input  a_valid, a_data, a_last,
    input  b_valid, b_data, b_last,
    input  out_ready,
    output a_ready, b_ready,
    output out_valid, out_data, out_last, out_sel, sel
  );
endinterface

// File: rtl/mux_2x1_rr_merge.sv
// Round-robin 2:1 stream merge with packet lock into a single-entry output register.
// Latency 1 cycle; loads while draining, so a full register with out_ready=0 deasserts both readies.
module mux_2x1_rr_merge #(
  parameter int WIDTH    = 8,
  parameter bit PKT_LOCK = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux_2x1_rr_merge_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             out_sel_q, out_sel_d;

  logic             grant;
  logic             load_en;
  logic             take;
  logic             beat_last;

  // Grant follows the lock; when unlocked, a lone requester wins, otherwise the pointer decides.
  always_comb begin
    grant = ptr_q;
    case (state_q)
      LOCK_A:  grant = 1'b1;
      LOCK_B:  grant = 1'b0;
      default: begin
        if (bus.a_valid && !bus.b_valid)      grant = 1'b1;
        else if (bus.b_valid && !bus.a_valid) grant = 1'b0;
      end
    endcase
  end

  assign load_en   = !out_valid_q || bus.out_ready;
  assign take      = load_en && (grant ? bus.a_valid : bus.b_valid);
  assign beat_last = grant ? bus.a_last : bus.b_last;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    if (take) begin
      out_valid_d = 1'b1;
      out_data_d  = grant ? bus.a_data : bus.b_data;
      out_last_d  = beat_last;
      out_sel_d   = grant;
      if (beat_last || !PKT_LOCK) begin
        state_d = IDLE;
        ptr_d   = !grant;
      end else begin
        state_d = grant ? LOCK_A : LOCK_B;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign bus.sel       = grant;
  assign bus.a_ready   = load_en && grant;
  assign bus.b_ready   = load_en && !grant;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_2x1_rr_merge.sv
// Bench for mux_2x1_rr_merge: packet-queue sources against a per-cycle arbitration model, directed scenarios then random traffic.
module tb_mux_2x1_rr_merge;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_2x1_rr_merge_if #(.WIDTH(W)) bus ();

  mux_2x1_rr_merge #(.WIDTH(W), .PKT_LOCK(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef logic [W:0] beat_t;  // {last, data}

  int n_checks = 0;
  int n_fail   = 0;

  beat_t      qa[$];
  beat_t      qb[$];
  logic [7:0] obs_d[$];
  logic       obs_s[$];
  bit         a_offer, b_offer;

  // Reference: owner 0 = nobody holds a packet, 1 = A, 2 = B; turn_a = A wins a tie.
  int         m_owner;
  bit         m_turn_a;
  bit         m_ov;
  logic [7:0] m_od;
  bit         m_ol;
  bit         m_os;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner  = 0;
    m_turn_a = 1'b1;
    m_ov     = 1'b0;
    m_od     = '0;
    m_ol     = 1'b0;
    m_os     = 1'b0;
    a_offer  = 1'b0;
    b_offer  = 1'b0;
    qa.delete();
    qb.delete();
  endtask

  task automatic drive_idle();
    bus.a_valid   = 1'b0;
    bus.a_data    = '0;
    bus.a_last    = 1'b0;
    bus.b_valid   = 1'b0;
    bus.b_data    = '0;
    bus.b_last    = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  // Asynchronous reset applied between edges; output must clear without a clock.
  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_out_sel", bus.out_sel, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input bit ordy, output bit a_took, output bit b_took);
    bit    es;
    bit    ld;
    beat_t bt;
    @(negedge clk);
    bus.a_valid   = a_offer;
    bus.a_data    = a_offer ? qa[0][7:0] : 8'h00;
    bus.a_last    = a_offer ? qa[0][8] : 1'b0;
    bus.b_valid   = b_offer;
    bus.b_data    = b_offer ? qb[0][7:0] : 8'h00;
    bus.b_last    = b_offer ? qb[0][8] : 1'b0;
    bus.out_ready = ordy;
    #1;
    if (m_owner == 1)                es = 1'b1;
    else if (m_owner == 2)           es = 1'b0;
    else if (a_offer && !b_offer)    es = 1'b1;
    else if (b_offer && !a_offer)    es = 1'b0;
    else                             es = m_turn_a;
    ld = !m_ov || ordy;
    check("sel", bus.sel, es);
    check("a_ready", bus.a_ready, ld && es);
    check("b_ready", bus.b_ready, ld && !es);
    check("out_valid", bus.out_valid, m_ov);
    if (m_ov) begin
      check("out_data", bus.out_data, m_od);
      check("out_last", bus.out_last, m_ol);
      check("out_sel", bus.out_sel, m_os);
      if (ordy && bus.out_valid) begin
        obs_d.push_back(bus.out_data);
        obs_s.push_back(bus.out_sel);
      end
    end
    a_took = ld && es && a_offer;
    b_took = ld && !es && b_offer;
    if (a_took || b_took) begin
      bt   = a_took ? qa[0] : qb[0];
      m_ov = 1'b1;
      m_od = bt[7:0];
      m_ol = bt[8];
      m_os = a_took;
      if (bt[8]) begin
        m_owner  = 0;
        m_turn_a = !a_took;
      end else begin
        m_owner = a_took ? 1 : 2;
      end
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    @(posedge clk);
  endtask

  // A source, once offering, holds its beat until accepted; pct only gates starting a new offer.
  task automatic run_cycles(input int n, input int rdy_pct, input int a_pct, input int b_pct);
    bit at, bt;
    for (int c = 0; c < n; c++) begin
      if (!a_offer && qa.size() > 0 && int'($urandom_range(99)) < a_pct) a_offer = 1'b1;
      if (!b_offer && qb.size() > 0 && int'($urandom_range(99)) < b_pct) b_offer = 1'b1;
      step(int'($urandom_range(99)) < rdy_pct, at, bt);
      if (at) begin void'(qa.pop_front()); a_offer = 1'b0; end
      if (bt) begin void'(qb.pop_front()); b_offer = 1'b0; end
    end
  endtask

  task automatic check_obs(input string tag, input logic [7:0] exp_d[$], input logic exp_s[$]);
    check({tag, "_count"}, obs_d.size(), exp_d.size());
    for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      check({tag, "_data"}, obs_d[i], exp_d[i]);
      check({tag, "_src"}, obs_s[i], exp_s[i]);
    end
    obs_d.delete();
    obs_s.delete();
  endtask

  task automatic refill(ref beat_t q[$]);
    while (q.size() < 6)
      q.push_back({($urandom_range(2) == 0), 8'($urandom)});
  endtask

  initial begin
    logic [7:0] ed[$];
    logic       es[$];
    bit         at, bt;

    drive_idle();
    model_reset();
    #12;
    check("init_out_valid", bus.out_valid, 0);
    check("init_out_data", bus.out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single A beat 0x3C, then it drains.
    qa.push_back({1'b1, 8'h3C});
    run_cycles(1, 100, 100, 0);
    #1;
    check("single_valid", bus.out_valid, 1);
    check("single_data", bus.out_data, 8'h3C);
    check("single_sel", bus.out_sel, 1);
    check("single_last", bus.out_last, 1);
    run_cycles(1, 100, 0, 0);
    #1;
    check("single_drained", bus.out_valid, 0);
    obs_d.delete(); obs_s.delete();

    // B opens a packet and holds the register; reset lands in LOCK_B.
    qb.push_back({1'b0, 8'hAA});
    run_cycles(1, 100, 0, 100);
    run_cycles(1, 0, 0, 0);
    do_reset();
    obs_d.delete(); obs_s.delete();

    // Single-beat packets on both sides alternate starting with A after reset.
    for (int i = 0; i < 4; i++) begin
      qa.push_back({1'b1, 8'(8'h01 + i)});
      qb.push_back({1'b1, 8'(8'h81 + i)});
    end
    run_cycles(9, 100, 100, 100);
    ed = '{8'h01, 8'h81, 8'h02, 8'h82, 8'h03, 8'h83, 8'h04, 8'h84};
    es = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    check_obs("alternate", ed, es);

    // A 3-beat packet holds the grant against a waiting B.
    qa.push_back({1'b0, 8'h10});
    qa.push_back({1'b0, 8'h11});
    qa.push_back({1'b1, 8'h12});
    qb.push_back({1'b1, 8'hF0});
    run_cycles(6, 100, 100, 100);
    ed = '{8'h10, 8'h11, 8'h12, 8'hF0};
    es = '{1'b1, 1'b1, 1'b1, 1'b0};
    check_obs("pkt_lock", ed, es);

    // Downstream stall with 0x55 held, then drain and load together.
    qa.push_back({1'b1, 8'h55});
    qa.push_back({1'b1, 8'h56});
    run_cycles(1, 100, 100, 0);
    run_cycles(4, 0, 100, 0);
    #1;
    check("stall_data", bus.out_data, 8'h55);
    check("stall_a_ready", bus.a_ready, 0);
    run_cycles(1, 100, 100, 0);
    #1;
    check("reload_valid", bus.out_valid, 1);
    check("reload_data", bus.out_data, 8'h56);
    run_cycles(1, 100, 0, 0);
    ed = '{8'h55, 8'h56};
    es = '{1'b1, 1'b1};
    check_obs("stall", ed, es);

    // A bubbles mid-packet while B waits; lock must hold.
    qa.push_back({1'b0, 8'h20});
    qa.push_back({1'b0, 8'h21});
    qa.push_back({1'b1, 8'h22});
    qb.push_back({1'b1, 8'hB0});
    run_cycles(1, 100, 100, 0);
    run_cycles(2, 100, 0, 100);
    #1;
    check("bubble_sel", bus.sel, 1);
    check("bubble_b_ready", bus.b_ready, 0);
    run_cycles(5, 100, 100, 100);
    ed = '{8'h20, 8'h21, 8'h22, 8'hB0};
    es = '{1'b1, 1'b1, 1'b1, 1'b0};
    check_obs("bubble", ed, es);

    // Random traffic with changing pressure; one mid-run reset.
    for (int phase = 0; phase < 6; phase++) begin
      int rp, ap, bp;
      rp = (phase == 0) ? 100 : int'($urandom_range(30, 100));
      ap = int'($urandom_range(20, 100));
      bp = int'($urandom_range(20, 100));
      for (int c = 0; c < 500; c++) begin
        refill(qa);
        refill(qb);
        run_cycles(1, rp, ap, bp);
      end
      if (phase == 3) do_reset();
    end

    // Flush to an empty register.
    at = 1'b0; bt = 1'b0;
    a_offer = 1'b0; b_offer = 1'b0;
    step(1'b1, at, bt);
    step(1'b1, at, bt);
    check("final_idle", bus.out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, limit %0d", 2000000);
    $fatal(1);
  end

endmodule

// File: doc/mux_2x1_rr_merge.md
Name: mux_2x1_rr_merge

Overview:
- Upstream stage for the 2:1 select mux: merges two valid/ready streams (A, B) into one registered output stream.
- Round-robin arbitration with packet lock: once a source wins, it keeps the grant until its beat with last=1 is transferred.
- Drives the select decision (sel) and presents the chosen data through a single-entry output register.

Parameters:
- WIDTH, 8, data width of a_data, b_data and out_data.
- PKT_LOCK, 1, 1 = hold grant until last beat; 0 = re-arbitrate every beat (a_last/b_last are passed through only).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- a_valid  input  1  source A beat available.
- a_ready  output  1  A beat accepted this cycle when a_valid & a_ready.
- a_data  input  WIDTH  source A data.
- a_last  input  1  final beat of an A packet.
- b_valid  input  1  source B beat available.
- b_ready  output  1  B handshake, same rules as A.
- b_data  input  WIDTH  source B data.
- b_last  input  1  final beat of a B packet.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  registered merged data.
- out_last  output  1  registered last flag.
- out_sel  output  1  source of the beat in the output register: 1 = A, 0 = B. Matches the mux convention of select==1 picks A.
- sel  output  1  current combinational grant: 1 = A, 0 = B.

Behaviour:
- Reset (rst_n low, async):
  - out_valid=0, out_data=0, out_last=0, out_sel=0.
  - FSM state=IDLE; round-robin pointer favours A.
- load_en = !out_valid | out_ready. The register can accept a new beat in the same cycle it drains, so sustained throughput is one beat per cycle.
- Handshake outputs:
  - a_ready = load_en & sel;  b_ready = load_en & !sel.
  - The ready of the non-granted source is always 0.
- Latency: an input beat accepted at edge N appears on out_* immediately after edge N (one register stage).
- out_* hold stable while out_valid & !out_ready. No input is accepted then.
- FSM states:
  - IDLE: grant by request.
    - Only A valid -> sel=1. Only B valid -> sel=0.
    - Both valid -> sel = pointer.
    - Neither valid -> sel = pointer (no transfer).
  - LOCK_A: sel=1 regardless of b_valid.
  - LOCK_B: sel=0 regardless of a_valid.
- Transitions, evaluated on each accepted beat only:
  - Accepted beat with last=0 and PKT_LOCK=1 -> LOCK_A or LOCK_B for the winner.
  - Accepted beat with last=1 -> IDLE, and pointer flips to the other source.
  - PKT_LOCK=0: FSM stays in IDLE; pointer flips after every accepted beat.
- No accepted beat: state and pointer unchanged. A stalled locked packet keeps its lock even while the locked source has valid=0 (a bubble mid-packet).
- If a source drops valid in IDLE without a handshake, no state change occurs. Sources are required not to do this, but the block must not lock in this case.
- Simultaneous drain and load: out_* take the new beat; out_valid stays 1.
- Reset mid-packet: lock is cleared, the output beat is discarded, and the pointer returns to A.

Test Plan:
- Reset while out_valid=1 in LOCK_B -> next cycle out_valid=0, out_data=0, state IDLE; with both valid, A wins first.
- Single A beat, a_data=0x3C, a_last=1, out_ready=1 -> a_ready=1 at cycle 0; out_valid=1, out_data=0x3C, out_sel=1, out_last=1 at cycle 1; out_valid=0 at cycle 2.
- Both streams continuously valid with single-beat packets (last=1), out_ready=1 -> out_sel alternates 1,0,1,0. A values 0x01..0x04 interleave with B values 0x81..0x84, one beat per cycle with no bubbles.
- A sends a 3-beat packet 0x10,0x11,0x12 (last on the third) while B is valid throughout with 0xF0 -> output 0x10,0x11,0x12,0xF0; b_ready=0 for the first 3 accept cycles.
- out_ready held 0 for 4 cycles with out_data=0x55 -> out_* stable, a_ready=b_ready=0; on release, 0x55 drains and the next beat loads in the same cycle.
- A packet stalls mid-packet (a_valid=0 for 2 cycles, b_valid=1) -> sel stays 1, b_ready=0; A resumes and completes, then B is granted.
